// File: rtl/bus_copy_engine.sv
// bus_copy_engine: femto-bus initiator that copies a byte range from src to dst, one read/write pair per beat
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module bus_copy_engine #(
  parameter int AW      = 32,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [AW-1:0]             src,
  input  logic [AW-1:0]             dst,
  input  logic [LEN_W-1:0]          len,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [AW-1:0]             err_addr,
  output logic [AW-1:0]             bus_addr,
  output logic                      bus_w_rb,
  output logic [`BUS_ACC_WIDTH-1:0] bus_acc,
  output logic [`BUS_WIDTH-1:0]     bus_wdata,
  output logic                      bus_req,
  input  logic [`BUS_WIDTH-1:0]     bus_rdata,
  input  logic                      bus_resp,
  input  logic                      bus_fault
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;

  state_t                    state_q;
  logic [AW-1:0]             src_q, dst_q, src_d, dst_d;
  logic [LEN_W-1:0]          rem_q, rem_d;
  logic [CW-1:0]             cnt_q;
  logic [2:0]                n;
  logic [`BUS_WIDTH-1:0]     rmask;
  logic                      tmo;

  // widest access allowed by the combined alignment of both pointers and the bytes left
  function automatic logic [`BUS_ACC_WIDTH-1:0] pick(input logic [1:0] a, input logic [LEN_W-1:0] r);
    return (a == 2'b00 && r >= LEN_W'(4)) ? `BUS_ACC_4B :
           (!a[0] && r >= LEN_W'(2))      ? `BUS_ACC_2B : `BUS_ACC_1B;
  endfunction

  // beat size, read-data mask and post-beat pointers derived from the held access size
  always_comb begin
    n     = bus_acc == `BUS_ACC_4B ? 3'd4 : bus_acc == `BUS_ACC_2B ? 3'd2 : 3'd1;
    rmask = bus_acc == `BUS_ACC_4B ? '1 : bus_acc == `BUS_ACC_2B ? `BUS_WIDTH'(16'hFFFF) : `BUS_WIDTH'(8'hFF);
    src_d = src_q + AW'(n);
    dst_d = dst_q + AW'(n);
    rem_d = rem_q - LEN_W'(n);
    tmo   = cnt_q >= CW'(TIMEOUT - 1);
  end

  // copy sequencer; bus_wdata doubles as the read-data holding register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_addr  <= '0;
      bus_addr  <= '0;
      bus_w_rb  <= 1'b0;
      bus_acc   <= `BUS_ACC_1B;
      bus_wdata <= '0;
      bus_req   <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          err <= 1'b0;
          if (len == '0) done <= 1'b1;
          else begin
            src_q    <= src;
            dst_q    <= dst;
            rem_q    <= len;
            busy     <= 1'b1;
            bus_req  <= 1'b1;
            bus_w_rb <= 1'b0;
            bus_addr <= src;
            bus_acc  <= pick(src[1:0] | dst[1:0], len);
            state_q  <= RD_REQ;
          end
        end
        RD_REQ, WR_REQ: begin
          bus_req <= 1'b0;
          cnt_q   <= CW'(1);
          if (bus_fault) begin
            err      <= 1'b1;
            busy     <= 1'b0;
            err_addr <= bus_addr;
            state_q  <= IDLE;
          end else state_q <= state_q == RD_REQ ? RD_WAIT : WR_WAIT;
        end
        RD_WAIT, WR_WAIT: begin
          if (bus_resp && state_q == RD_WAIT) begin
            bus_wdata <= bus_rdata & rmask;
            bus_req   <= 1'b1;
            bus_w_rb  <= 1'b1;
            bus_addr  <= dst_q;
            state_q   <= WR_REQ;
          end else if (bus_resp) begin
            src_q <= src_d;
            dst_q <= dst_d;
            rem_q <= rem_d;
            if (rem_d == '0) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              state_q <= IDLE;
            end else begin
              bus_req  <= 1'b1;
              bus_w_rb <= 1'b0;
              bus_addr <= src_d;
              bus_acc  <= pick(src_d[1:0] | dst_d[1:0], rem_d);
              state_q  <= RD_REQ;
            end
          end else if (tmo) begin
            err      <= 1'b1;
            busy     <= 1'b0;
            err_addr <= bus_addr;
            state_q  <= IDLE;
          end else cnt_q <= cnt_q + CW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_copy_engine.sv
// tb_bus_copy_engine: directed copies against a byte-memory responder, scoreboarded bus requests and completions
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module tb_bus_copy_engine;
  logic        clk = 1'b0;
  logic        rstn, start;
  logic [31:0] src, dst;
  logic [15:0] len;
  logic        busy, done, err;
  logic [31:0] err_addr, bus_addr, bus_wdata, bus_rdata;
  logic        bus_w_rb, bus_req, bus_resp, bus_fault;
  logic [1:0]  bus_acc;

  bus_copy_engine dut (
    .clk(clk), .rstn(rstn), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr),
    .bus_addr(bus_addr), .bus_w_rb(bus_w_rb), .bus_acc(bus_acc), .bus_wdata(bus_wdata),
    .bus_req(bus_req), .bus_rdata(bus_rdata), .bus_resp(bus_resp), .bus_fault(bus_fault)
  );

  always #5 clk = ~clk;

  typedef struct { logic w; logic [31:0] a; logic [1:0] acc; logic [31:0] wd; } breq_t;
  typedef struct { logic e; logic [31:0] a; } term_t;
  breq_t bq[$];
  term_t tq[$];

  int          n_vec = 0, n_miss = 0;
  logic [7:0]  mem [0:65535];
  logic        fault_en = 1'b0, resp_en = 1'b1;
  logic [31:0] fault_addr = '0;
  logic        err_prev;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm, input logic [31:0] act);
    n_vec++;
    n_miss++;
    $display("FAIL %s: got %h expected nothing", nm, act);
  endtask

  task automatic push_req(input logic w, input logic [31:0] a, input logic [1:0] acc, input logic [31:0] wd);
    breq_t e;
    e.w = w; e.a = a; e.acc = acc; e.wd = wd;
    bq.push_back(e);
  endtask

  task automatic push_term(input logic e, input logic [31:0] a);
    term_t t;
    t.e = e; t.a = a;
    tq.push_back(t);
  endtask

  function automatic logic [63:0] rd(input logic [15:0] a, input int n);
    rd = '0;
    for (int i = 0; i < n; i++) rd[8*i +: 8] = mem[a + 16'(i)];
  endfunction

  task automatic put(input logic [15:0] a, input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) mem[a + 16'(i)] = v[8*i +: 8];
  endtask

  task automatic go(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    @(posedge clk); #1;
    src = s; dst = d; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input int max, input int first, output int k);
    k = -1;
    for (int i = first; i < max; i++) begin
      @(negedge clk);
      if (done || err) begin k = i; break; end
    end
    if (k < 0) miss("wait_end_timeout", 32'(max));
  endtask

  // monitor: every request and every completion is checked against the head of its queue
  always @(negedge clk) begin
    if (bus_req) begin
      if (bq.size() == 0) miss("unexpected_req", bus_addr);
      else begin
        breq_t e;
        e = bq.pop_front();
        chk("req_w_rb", 64'(bus_w_rb), 64'(e.w));
        chk("req_addr", 64'(bus_addr), 64'(e.a));
        chk("req_acc", 64'(bus_acc), 64'(e.acc));
        if (e.w) chk("req_wdata", 64'(bus_wdata), 64'(e.wd));
      end
    end
    if (done || (err && !err_prev)) begin
      if (tq.size() == 0) miss("unexpected_term", {30'd0, err, done});
      else begin
        term_t t;
        t = tq.pop_front();
        chk("term_err", 64'(err), 64'(t.e));
        chk("term_done", 64'(done), 64'(!t.e));
        if (t.e) chk("term_err_addr", 64'(err_addr), 64'(t.a));
      end
    end
    err_prev <= err;
  end

  // responder: fault decided in the req cycle, resp one cycle after req
  initial begin
    logic        pend, pw;
    logic [31:0] pa, pwd;
    logic [1:0]  pacc;
    int          nb;
    bus_resp = 1'b0; bus_fault = 1'b0; bus_rdata = '0;
    forever begin
      @(negedge clk);
      bus_fault = fault_en && bus_req && bus_w_rb && bus_addr == fault_addr;
      pend = resp_en && bus_req === 1'b1 && !bus_fault;
      pw = bus_w_rb; pa = bus_addr; pacc = bus_acc; pwd = bus_wdata;
      @(posedge clk); #1;
      bus_fault = 1'b0;
      bus_resp  = pend;
      bus_rdata = 32'hEEEE_EEEE;
      if (pend) begin
        nb = pacc == `BUS_ACC_4B ? 4 : pacc == `BUS_ACC_2B ? 2 : 1;
        for (int i = 0; i < nb; i++)
          if (pw) mem[pa[15:0] + 16'(i)] = pwd[8*i +: 8];
          else bus_rdata[8*i +: 8] = mem[pa[15:0] + 16'(i)];
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rstn = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_req", 64'(bus_req), 0);
    chk("rst_w_rb", 64'(bus_w_rb), 0);
    chk("rst_acc", 64'(bus_acc), 64'(`BUS_ACC_1B));
    chk("rst_addr", 64'(bus_addr), 0);
    chk("rst_wdata", 64'(bus_wdata), 0);
    chk("rst_err_addr", 64'(err_addr), 0);
    @(posedge clk); #1 rstn = 1'b1;

    // aligned 8-byte copy, two 4B beats
    put(16'h0100, 64'h8877_6655_4433_2211, 8);
    push_req(0, 32'h100, `BUS_ACC_4B, 0);
    push_req(1, 32'h2000, `BUS_ACC_4B, 32'h4433_2211);
    push_req(0, 32'h104, `BUS_ACC_4B, 0);
    push_req(1, 32'h2004, `BUS_ACC_4B, 32'h8877_6655);
    push_term(0, 0);
    go(32'h100, 32'h2000, 16'd8);
    @(negedge clk);
    chk("t1_busy", 64'(busy), 1);
    wait_end(100, 1, k);
    chk("t1_done_cycle", 64'(k), 8);
    @(negedge clk);
    chk("t1_busy_after", 64'(busy), 0);
    chk("t1_mem", rd(16'h2000, 8), 64'h8877_6655_4433_2211);

    // odd alignment on both ends: 1B, 2B, 2B
    put(16'h0101, 64'hA5_A4A3_A2A1, 5);
    push_req(0, 32'h101, `BUS_ACC_1B, 0);
    push_req(1, 32'h2001, `BUS_ACC_1B, 32'hA1);
    push_req(0, 32'h102, `BUS_ACC_2B, 0);
    push_req(1, 32'h2002, `BUS_ACC_2B, 32'hA3A2);
    push_req(0, 32'h104, `BUS_ACC_2B, 0);
    push_req(1, 32'h2004, `BUS_ACC_2B, 32'hA5A4);
    push_term(0, 0);
    go(32'h101, 32'h2001, 16'd5);
    wait_end(100, 0, k);
    chk("t2_done_cycle", 64'(k), 12);
    chk("t2_mem", rd(16'h2000, 7), 64'h77_A5A4_A3A2_A111);

    // common alignment of 2 between src and dst
    put(16'h0100, 64'hAABB_CCDD, 4);
    push_req(0, 32'h100, `BUS_ACC_2B, 0);
    push_req(1, 32'h2002, `BUS_ACC_2B, 32'hCCDD);
    push_req(0, 32'h102, `BUS_ACC_2B, 0);
    push_req(1, 32'h2004, `BUS_ACC_2B, 32'hAABB);
    push_term(0, 0);
    go(32'h100, 32'h2002, 16'd4);
    wait_end(100, 0, k);
    chk("t3_mem", rd(16'h2002, 4), 64'hAABB_CCDD);

    // write fault on the second beat
    put(16'h0300, 64'h0807_0605_0403_0201, 8);
    fault_en = 1'b1; fault_addr = 32'h2004;
    push_req(0, 32'h300, `BUS_ACC_4B, 0);
    push_req(1, 32'h2000, `BUS_ACC_4B, 32'h0403_0201);
    push_req(0, 32'h304, `BUS_ACC_4B, 0);
    push_req(1, 32'h2004, `BUS_ACC_4B, 32'h0807_0605);
    push_term(1, 32'h2004);
    go(32'h300, 32'h2000, 16'd8);
    wait_end(100, 0, k);
    chk("t4_err_cycle", 64'(k), 7);
    chk("t4_busy", 64'(busy), 0);
    repeat (10) @(negedge clk);
    chk("t4_err_sticky", 64'(err), 1);
    chk("t4_bq_empty", 64'(bq.size()), 0);
    fault_en = 1'b0;
    push_term(0, 0);
    go(32'h0, 32'h0, 16'd0);
    wait_end(10, 0, k);
    chk("t4_err_cleared", 64'(err), 0);

    // responder silent: timeout on the read
    resp_en = 1'b0;
    push_req(0, 32'h400, `BUS_ACC_4B, 0);
    push_term(1, 32'h400);
    go(32'h400, 32'h3000, 16'd4);
    wait_end(400, 0, k);
    chk("t5_timeout_cycle", 64'(k), 255);
    resp_en = 1'b1;
    repeat (3) @(negedge clk);

    // zero length: done next cycle, no bus traffic
    push_term(0, 0);
    go(32'h500, 32'h2100, 16'd0);
    wait_end(10, 0, k);
    chk("t6_len0_cycle", 64'(k), 0);
    chk("t6_len0_err", 64'(err), 0);
    chk("t6_len0_busy", 64'(busy), 0);

    // start while busy is ignored
    put(16'h0500, 64'h5D5C_5B5A, 4);
    put(16'h0600, 64'hFFFF_FFFF_FFFF_FFFF, 8);
    push_req(0, 32'h500, `BUS_ACC_4B, 0);
    push_req(1, 32'h2100, `BUS_ACC_4B, 32'h5D5C_5B5A);
    push_term(0, 0);
    go(32'h500, 32'h2100, 16'd4);
    repeat (2) @(negedge clk);
    go(32'h600, 32'h2104, 16'd8);
    wait_end(100, 0, k);
    repeat (5) @(negedge clk);
    chk("t6_mem", rd(16'h2100, 8), 64'h0000_0000_5D5C_5B5A);
    chk("t6_bq_empty", 64'(bq.size()), 0);

    // reset in the middle of a transfer; the late resp must be ignored
    push_req(0, 32'h100, `BUS_ACC_4B, 0);
    go(32'h100, 32'h3100, 16'd4);
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t7_busy", 64'(busy), 0);
    chk("t7_req", 64'(bus_req), 0);
    chk("t7_addr", 64'(bus_addr), 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (6) @(negedge clk);
    chk("t7_mem", rd(16'h3100, 4), 64'h0);
    chk("t7_bq_empty", 64'(bq.size()), 0);
    chk("t7_tq_empty", 64'(tq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/bus_copy_engine.md
Name: bus_copy_engine

Overview:
- Femto bus initiator: copies a byte range from a source to a destination address on the MCU bus (e.g. ROM image to SRAM at boot).
- Sits between a control source (boot FSM or config registers) and the bus fabric.
- Drives the same addr/w_rb/acc/req/wdata signals that ROM, SRAM and peripheral controllers consume; consumes their rdata/resp/fault.
- Picks the widest legal access per beat from the current alignment and the remaining length.

Parameters:
- AW, 32, bus address width.
- LEN_W, 16, width of the byte-count input.
- TIMEOUT, 255, maximum cycles from a req pulse to resp before the transfer is declared a timeout error; must be ≥1.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; launches a copy, sampled only in IDLE.
- src  in  AW  source byte address, latched on start.
- dst  in  AW  destination byte address, latched on start.
- len  in  LEN_W  byte count, latched on start.
- busy  out  1  high from the cycle after an accepted start until done or err.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky error flag; cleared by the next accepted start or by reset.
- err_addr  out  AW  address of the failing access.
- bus_addr  out  AW  bus address.
- bus_w_rb  out  1  1 = write, 0 = read.
- bus_acc  out  `BUS_ACC_WIDTH  access size (`BUS_ACC_1B/2B/4B).
- bus_wdata  out  `BUS_WIDTH  write data, right-justified (addressed byte in [7:0]).
- bus_req  out  1  request strobe.
- bus_rdata  in  `BUS_WIDTH  read data, right-justified; valid in the resp cycle.
- bus_resp  in  1  access complete.
- bus_fault  in  1  combinational reject, valid in the req cycle.

Behaviour:
- Reset: state IDLE. busy, done, err, bus_req and bus_w_rb are 0. err_addr, bus_addr and bus_wdata are 0. bus_acc = `BUS_ACC_1B.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
- IDLE:
  - start with len ≠ 0: latch cur_src, cur_dst and rem, clear err, go to RD_REQ.
  - start with len = 0: done pulses the next cycle, no bus activity, err cleared.
- Access size is computed at RD_REQ entry and held for the read/write pair. With a = cur_src|cur_dst:
  - a[1:0]=0 and rem≥4 → 4B;
  - else a[0]=0 and rem≥2 → 2B;
  - else 1B.
- RD_REQ:
  - bus_req=1 for exactly one cycle, bus_w_rb=0, bus_addr=cur_src.
  - bus_fault=1 in this cycle → error, err_addr=cur_src.
  - Otherwise go to RD_WAIT.
- RD_WAIT:
  - bus_req=0.
  - On bus_resp: capture bus_rdata into a holding register, masked to the access width (upper bytes zeroed), then go to WR_REQ.
- WR_REQ:
  - bus_req=1 for one cycle, bus_w_rb=1, bus_addr=cur_dst, bus_wdata=holding register.
  - bus_fault → error with err_addr=cur_dst; otherwise go to WR_WAIT.
- WR_WAIT, on bus_resp:
  - cur_src += n, cur_dst += n, rem -= n, where n is 1/2/4 bytes.
  - rem reaching 0 → done pulse, go to IDLE; else go to RD_REQ.
- Throughput with a 1-cycle responder: 4 cycles per beat (req, wait, req, wait).
- Timeout:
  - A counter resets on each req and counts in the WAIT states.
  - Reaching TIMEOUT without resp → error, err_addr = the pending address.
- Error action: err=1, busy=0, bus_req=0, return to IDLE, no done pulse.
- bus_addr, bus_acc, bus_w_rb and bus_wdata are held stable from the req cycle through resp; they are don't-care in IDLE.
- Only one outstanding access. Never issue req while waiting.
- A bus_resp arriving in IDLE, RD_REQ or WR_REQ is ignored.
- start while busy is ignored; the in-flight copy continues unchanged.
- Address arithmetic wraps modulo 2^AW and is not flagged.
- Reset mid-transfer: all state returns to reset values next edge. A late resp after reset is ignored.

Test Plan:
- src=0x100, dst=0x2000, len=8, 1-cycle responder → two 4B reads at 0x100/0x104, two 4B writes at 0x2000/0x2004. Data copied exactly. done asserted 8 cycles after the first req. busy low the cycle after done.
- src=0x101, dst=0x2001, len=5 → access sizes 1B@0x101, 2B@0x102, 2B@0x104 (both ends). Written bytes match source. No fault.
- src=0x100, dst=0x2002, len=4 → common alignment 2, so two 2B beats. Read data 0xAABBCCDD at 0x100 gives writes 0xCCDD@0x2002 and 0xAABB@0x2004.
- Responder asserts bus_fault on the write to 0x2004 during an 8-byte copy → err=1, err_addr=0x2004, no further bus_req, done never pulses. A subsequent start clears err.
- Responder never asserts resp, TIMEOUT=255 → err=1 exactly 255 cycles after the read req, err_addr=src.
- len=0 start → done one cycle later, bus_req never asserted. start pulsed while busy mid-copy → ignored, original copy completes.
